flag_unit: RTL and testbench

FLAG_UNIT -- requirements
Module: flag_unit

---
 rtl/alu_pkg.sv | 38 +++
 rtl/flag_unit_if.sv | 34 +++
 rtl/cond_eval.sv | 29 ++
 rtl/flag_unit.sv | 70 +++++++
 tb/tb_flag_unit.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, condition codes and the NZCV flag layout.
package alu_pkg;

  localparam logic [2:0] PASS_B = 3'b000;
  localparam logic [2:0] ADD    = 3'b010;
  localparam logic [2:0] SUB    = 3'b011;
  localparam logic [2:0] AND    = 3'b100;
  localparam logic [2:0] OR     = 3'b101;
  localparam logic [2:0] XOR    = 3'b110;

  typedef enum logic [3:0] {
    COND_EQ  = 4'd0,
    COND_NE  = 4'd1,
    COND_HS  = 4'd2,
    COND_LO  = 4'd3,
    COND_MI  = 4'd4,
    COND_PL  = 4'd5,
    COND_VS  = 4'd6,
    COND_VC  = 4'd7,
    COND_HI  = 4'd8,
    COND_LS  = 4'd9,
    COND_GE  = 4'd10,
    COND_LT  = 4'd11,
    COND_GT  = 4'd12,
    COND_LE  = 4'd13,
    COND_AL  = 4'd14,
    COND_AL2 = 4'd15
  } cond_t;

  // N sits in bit 3 so the packed value matches the architectural NZCV nibble.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage

// File: rtl/flag_unit_if.sv
// Bus between the execute stage / branch requester (master) and flag_unit (slave).
interface flag_unit_if;
  logic       ex_valid;
  logic       ex_setflags;
  logic       alu_negative;
  logic       alu_zero;
  logic       alu_overflow;
  logic       alu_carry_out;
  logic       br_valid;
  logic [3:0] br_cond;
  logic       br_is_cbz;
  logic       cbz_zero;
  logic       stall;
  logic       flush;
  logic [3:0] flags_q;
  logic       br_resp_valid;
  logic       br_taken;
  logic       br_retry;

  // Handshake: a request is taken when br_valid=1 with no stall, flush or br_retry in
  // the same cycle; its result shows as br_resp_valid/br_taken one edge later, and a
  // retried request must be re-presented unchanged on the following cycle.
  modport master (
    output ex_valid, ex_setflags, alu_negative, alu_zero, alu_overflow, alu_carry_out,
    output br_valid, br_cond, br_is_cbz, cbz_zero, stall, flush,
    input  flags_q, br_resp_valid, br_taken, br_retry
  );

  modport slave (
    input  ex_valid, ex_setflags, alu_negative, alu_zero, alu_overflow, alu_carry_out,
    input  br_valid, br_cond, br_is_cbz, cbz_zero, stall, flush,
    output flags_q, br_resp_valid, br_taken, br_retry
  );
endinterface

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator over an NZCV set.
module cond_eval
  import alu_pkg::*;
(
  input  nzcv_t flags_i,
  input  cond_t cond_i,
  output logic  taken_o
);

  logic base;

  // Even codes carry the base test; odd codes invert it, except the AL pair.
  always_comb begin
    base = 1'b1;
    case (cond_i[3:1])
      3'd0:    base = flags_i.z;
      3'd1:    base = flags_i.c;
      3'd2:    base = flags_i.n;
      3'd3:    base = flags_i.v;
      3'd4:    base = flags_i.c & ~flags_i.z;
      3'd5:    base = ~(flags_i.n ^ flags_i.v);
      3'd6:    base = ~flags_i.z & ~(flags_i.n ^ flags_i.v);
      default: base = 1'b1;
    endcase
  end

  assign taken_o = (cond_i[3:1] == 3'b111) ? 1'b1 : (base ^ cond_i[0]);

endmodule

// File: rtl/flag_unit.sv
// NZCV flag register with one-cycle branch condition resolution.
// Define FLAG_FWD_EN to bypass same-cycle ALU flags into branch evaluation instead of retrying.
module flag_unit
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  flag_unit_if.slave  bus
);

  nzcv_t flags_q, flags_d;
  logic  resp_valid_q, resp_valid_d;
  logic  taken_q, taken_d;

  nzcv_t alu_nzcv;
  nzcv_t eval_flags;
  logic  flag_wr;
  logic  retry;
  logic  accept;
  logic  cond_taken;

  assign alu_nzcv = '{n: bus.alu_negative, z: bus.alu_zero,
                      c: bus.alu_carry_out, v: bus.alu_overflow};

  assign flag_wr = bus.ex_valid & bus.ex_setflags & ~bus.stall & ~bus.flush;

`ifdef FLAG_FWD_EN
  assign eval_flags = flag_wr ? alu_nzcv : flags_q;
  assign retry      = 1'b0;
`else
  // CBZ never depends on flags, so only a conditional branch collides with a write.
  assign eval_flags = flags_q;
  assign retry      = ~reset & bus.br_valid & ~bus.br_is_cbz & flag_wr;
`endif

  assign accept = bus.br_valid & ~bus.stall & ~bus.flush & ~retry;

  cond_eval u_cond_eval (
    .flags_i (eval_flags),
    .cond_i  (cond_t'(bus.br_cond)),
    .taken_o (cond_taken)
  );

  always_comb begin
    flags_d      = flag_wr ? alu_nzcv : flags_q;
    resp_valid_d = accept;
    taken_d      = taken_q;
    if (accept) begin
      taken_d = bus.br_is_cbz ? bus.cbz_zero : cond_taken;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q      <= '0;
      resp_valid_q <= 1'b0;
      taken_q      <= 1'b0;
    end else begin
      flags_q      <= flags_d;
      resp_valid_q <= resp_valid_d;
      taken_q      <= taken_d;
    end
  end

  assign bus.flags_q       = flags_q;
  assign bus.br_resp_valid = resp_valid_q;
  assign bus.br_taken      = taken_q;
  assign bus.br_retry      = retry;

endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: directed scenarios plus randomized traffic.
module tb_flag_unit;
  import alu_pkg::*;

`ifdef FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  flag_unit_if bus ();

  flag_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] m_flags;
  logic       m_valid;
  logic       m_taken;
  bit         m_retry;
  logic [0:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // 64-bit ALU reference producing {N,Z,C,V}; C on SUB means "no borrow".
  function automatic logic [3:0] alu_model(input logic [2:0] op, input logic [63:0] a,
                                           input logic [63:0] b);
    logic [64:0] s;
    logic [63:0] r;
    logic        c;
    logic        v;
    s = '0;
    case (op)
      ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[63:0];
        c = s[64];
        v = (a[63] == b[63]) && (r[63] != a[63]);
      end
      SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 65'd1;
        r = s[63:0];
        c = s[64];
        v = (a[63] != b[63]) && (r[63] != a[63]);
      end
      AND: begin
        r = a & b;
        c = 1'b0;
        v = 1'b0;
      end
      default: begin
        r = b;
        c = 1'b0;
        v = 1'b0;
      end
    endcase
    return {r[63], (r == 64'd0), c, v};
  endfunction

  function automatic bit cond_holds(input int code, input logic [3:0] f);
    bit n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (code)
      0:  return z;
      1:  return !z;
      2:  return c;
      3:  return !c;
      4:  return n;
      5:  return !n;
      6:  return v;
      7:  return !v;
      8:  return c && !z;
      9:  return !c || z;
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    bus.ex_valid      = 1'b0;
    bus.ex_setflags   = 1'b0;
    bus.alu_negative  = 1'b0;
    bus.alu_zero      = 1'b0;
    bus.alu_overflow  = 1'b0;
    bus.alu_carry_out = 1'b0;
    bus.br_valid      = 1'b0;
    bus.br_cond       = 4'd0;
    bus.br_is_cbz     = 1'b0;
    bus.cbz_zero      = 1'b0;
    bus.stall         = 1'b0;
    bus.flush         = 1'b0;
  endtask

  task automatic set_alu(input logic [3:0] f);
    bus.alu_negative  = f[3];
    bus.alu_zero      = f[2];
    bus.alu_carry_out = f[1];
    bus.alu_overflow  = f[0];
  endtask

  task automatic model_reset();
    m_flags = 4'b0000;
    m_valid = 1'b0;
    m_taken = 1'b0;
    m_retry = 1'b0;
    exp_q.delete();
  endtask

  // Called just after inputs were driven; checks retry, clocks once, checks registered outputs.
  task automatic run_cycle(input string tag);
    bit         wr;
    bit         acc;
    logic [3:0] alu_f;
    logic [3:0] src;
    logic [0:0] exp_t;
    #1;
    alu_f   = {bus.alu_negative, bus.alu_zero, bus.alu_carry_out, bus.alu_overflow};
    wr      = bus.ex_valid && bus.ex_setflags && !bus.stall && !bus.flush;
    m_retry = !FWD && bus.br_valid && !bus.br_is_cbz && wr;
    check_eq({tag, ".retry"}, bus.br_retry, m_retry);
    acc = bus.br_valid && !bus.stall && !bus.flush && !m_retry;
    src = (FWD && wr) ? alu_f : m_flags;
    if (acc) begin
      m_taken = bus.br_is_cbz ? bus.cbz_zero : cond_holds(int'(bus.br_cond), src);
      exp_q.push_back(m_taken);
    end
    m_valid = acc;
    if (wr) m_flags = alu_f;
    @(posedge clk);
    #1;
    check_eq({tag, ".flags"}, bus.flags_q, m_flags);
    check_eq({tag, ".resp_valid"}, bus.br_resp_valid, m_valid);
    check_eq({tag, ".taken_hold"}, bus.br_taken, m_taken);
    if (m_valid && exp_q.size() > 0) begin
      exp_t = exp_q.pop_front();
      check_eq({tag, ".taken_sb"}, bus.br_taken, exp_t);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    set_idle();
    reset = 1'b1;
    #1;
    check_eq("rst.flags", bus.flags_q, 4'b0000);
    check_eq("rst.resp_valid", bus.br_resp_valid, 1'b0);
    check_eq("rst.taken", bus.br_taken, 1'b0);
    check_eq("rst.retry", bus.br_retry, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Signed overflow on ADD, then B.GE on N==V.
    set_idle();
    bus.ex_valid = 1'b1; bus.ex_setflags = 1'b1;
    set_alu(alu_model(ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1));
    run_cycle("add_ovf");
    check_eq("add_ovf.nzcv", bus.flags_q, 4'b1001);
    set_idle();
    bus.br_valid = 1'b1; bus.br_cond = COND_GE;
    run_cycle("b_ge");
    check_eq("b_ge.taken", bus.br_taken, 1'b1);

    // Equal SUB gives Z=1,C=1; EQ taken, HI not.
    set_idle();
    bus.ex_valid = 1'b1; bus.ex_setflags = 1'b1;
    set_alu(alu_model(SUB, 64'hDEAD_BEEF_DECA_FBAD, 64'hDEAD_BEEF_DECA_FBAD));
    run_cycle("sub_eq");
    check_eq("sub_eq.nzcv", bus.flags_q, 4'b0110);
    set_idle();
    bus.br_valid = 1'b1; bus.br_cond = COND_EQ;
    run_cycle("b_eq");
    check_eq("b_eq.taken", bus.br_taken, 1'b1);
    set_idle();
    bus.br_valid = 1'b1; bus.br_cond = COND_HI;
    run_cycle("b_hi");
    check_eq("b_hi.taken", bus.br_taken, 1'b0);

    // Clear flags with AND, then same-cycle carry-producing ADD with B.HS.
    set_idle();
    bus.ex_valid = 1'b1; bus.ex_setflags = 1'b1;
    set_alu(alu_model(AND, 64'hF0F0_0000_0000_0001, 64'h0F0F_0000_0000_0001));
    run_cycle("and_clr");
    set_idle();
    bus.ex_valid = 1'b1; bus.ex_setflags = 1'b1;
    set_alu(alu_model(ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1));
    bus.br_valid = 1'b1; bus.br_cond = COND_HS;
    run_cycle("hs_same");
    if (m_retry) begin
      set_idle();
      bus.br_valid = 1'b1; bus.br_cond = COND_HS;
      run_cycle("hs_retried");
    end
    check_eq("hs.resp_valid", bus.br_resp_valid, 1'b1);
    check_eq("hs.taken", bus.br_taken, 1'b1);

    // Flush and stall both suppress the flag write and the branch.
    set_idle();
    bus.ex_valid = 1'b1; bus.ex_setflags = 1'b1; set_alu(4'b1001);
    bus.br_valid = 1'b1; bus.br_cond = COND_AL; bus.flush = 1'b1;
    run_cycle("flush");
    check_eq("flush.nzcv", bus.flags_q, 4'b0110);
    check_eq("flush.resp", bus.br_resp_valid, 1'b0);
    set_idle();
    bus.ex_valid = 1'b1; bus.ex_setflags = 1'b1; set_alu(4'b1001);
    bus.br_valid = 1'b1; bus.br_cond = COND_AL; bus.stall = 1'b1;
    #1;
    check_eq("stall.retry_comb", bus.br_retry, 1'b0);
    run_cycle("stall");
    check_eq("stall.nzcv", bus.flags_q, 4'b0110);
    check_eq("stall.resp", bus.br_resp_valid, 1'b0);

    // CBZ never retries and ignores flags (NE would be false on Z=1).
    set_idle();
    bus.ex_valid = 1'b1; bus.ex_setflags = 1'b1; set_alu(4'b0100);
    bus.br_valid = 1'b1; bus.br_is_cbz = 1'b1; bus.cbz_zero = 1'b1; bus.br_cond = COND_NE;
    run_cycle("cbz");
    check_eq("cbz.taken", bus.br_taken, 1'b1);

    // Reset in the middle of a response, with a new request already in flight.
    set_idle();
    bus.br_valid = 1'b1; bus.br_cond = COND_AL;
    run_cycle("pre_rst");
    bus.ex_valid = 1'b1; bus.ex_setflags = 1'b1; set_alu(4'b1111);
    bus.br_valid = 1'b1; bus.br_cond = COND_AL;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_eq("mid_rst.flags", bus.flags_q, 4'b0000);
    check_eq("mid_rst.resp_valid", bus.br_resp_valid, 1'b0);
    check_eq("mid_rst.taken", bus.br_taken, 1'b0);
    check_eq("mid_rst.retry", bus.br_retry, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_idle();
    run_cycle("post_rst");
    check_eq("post_rst.resp", bus.br_resp_valid, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      set_idle();
      bus.ex_valid    = 1'($urandom_range(0, 1));
      bus.ex_setflags = 1'($urandom_range(0, 1));
      set_alu(4'($urandom_range(0, 15)));
      bus.br_valid    = ($urandom_range(0, 9) < 6);
      bus.br_cond     = 4'($urandom_range(0, 15));
      bus.br_is_cbz   = ($urandom_range(0, 3) == 0);
      bus.cbz_zero    = 1'($urandom_range(0, 1));
      bus.stall       = ($urandom_range(0, 7) == 0);
      bus.flush       = ($urandom_range(0, 7) == 0);
      run_cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
